// File: rtl/deserializer_multilane.sv
// Multi-lane framed serial-to-parallel deserializer with an output FIFO.
// Completed words are pushed into the FIFO, and a push into a full FIFO is dropped and flagged.
module deserializer_multilane #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 1,
  parameter int LSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          start_i,
  input  logic [NUM_LANES-1:0]          serial_in_i,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         parallel_out_o,
  output logic                          valid_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int BEATS = DATA_WIDTH / NUM_LANES;
  localparam int CW    = $clog2(BEATS) + 1;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_frame_q, in_frame_d;
  logic                  overflow_q, overflow_d;
  logic [LW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic [LW-1:0]         level;
  logic                  push, pop, full, do_write;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  generate
    if (NUM_LANES == DATA_WIDTH) begin : g_full
      assign sr_shift = serial_in_i;
    end else if (LSB_FIRST != 0) begin : g_lsb
      assign sr_shift = {serial_in_i, sr_q[DATA_WIDTH-1:NUM_LANES]};
    end else begin : g_msb
      assign sr_shift = {sr_q[DATA_WIDTH-NUM_LANES-1:0], serial_in_i};
    end

    if (FIFO_DEPTH > 1) begin : g_idx
      assign wr_idx = wr_ptr_q[IW-1:0];
      assign rd_idx = rd_ptr_q[IW-1:0];
    end else begin : g_idx1
      assign wr_idx = '0;
      assign rd_idx = '0;
    end
  endgenerate

  // A start aborts any partial word; the pushed word includes the current beat.
  always_comb begin
    sr_d       = enable_i ? sr_shift : sr_q;
    cnt_d      = cnt_q;
    in_frame_d = in_frame_q;
    push       = 1'b0;
    if (start_i) begin
      if (enable_i && (BEATS == 1)) begin
        push       = 1'b1;
        in_frame_d = 1'b0;
        cnt_d      = '0;
      end else begin
        in_frame_d = 1'b1;
        cnt_d      = enable_i ? CW'(1) : '0;
      end
    end else if (in_frame_q && enable_i) begin
      if (cnt_q == LAST_BEAT) begin
        push       = 1'b1;
        in_frame_d = 1'b0;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level    = wr_ptr_q - rd_ptr_q;
  assign valid_o  = (level != '0);
  assign full     = (level == LW'(FIFO_DEPTH));
  assign pop      = valid_o && ready_i;
  assign do_write = push && (!full || pop);

  // A simultaneous pop frees the slot, so a full FIFO only drops when nothing leaves.
  always_comb begin
    overflow_d = push && full && !pop;
    wr_ptr_d   = wr_ptr_q + LW'(do_write);
    rd_ptr_d   = rd_ptr_q + LW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      in_frame_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      in_frame_q <= in_frame_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) mem[wr_idx] <= sr_d;
  end

  assign parallel_out_o = valid_o ? mem[rd_idx] : '0;
  assign busy_o         = in_frame_q;
  assign overflow_o     = overflow_q;
  assign level_o        = level;
endmodule

// File: tb/tb_deserializer_multilane.sv
// Bench for deserializer_multilane: MSB-first, LSB-first and 4-lane instances share one stimulus
// and are each checked every cycle against a word-level model.
module tb_deserializer_multilane;
  logic       clk = 1'b0;
  logic       rst, en, st, rdy;
  logic [3:0] ser;

  logic [7:0] pout [3];
  logic       vld [3], bsy [3], ovf [3];
  logic [1:0] lvl [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  deserializer_multilane #(.DATA_WIDTH(8), .NUM_LANES(1), .LSB_FIRST(0), .FIFO_DEPTH(2)) u_msb (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .start_i(st), .serial_in_i(ser[0:0]),
    .ready_i(rdy), .parallel_out_o(pout[0]), .valid_o(vld[0]), .busy_o(bsy[0]),
    .overflow_o(ovf[0]), .level_o(lvl[0]));

  deserializer_multilane #(.DATA_WIDTH(8), .NUM_LANES(1), .LSB_FIRST(1), .FIFO_DEPTH(2)) u_lsb (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .start_i(st), .serial_in_i(ser[0:0]),
    .ready_i(rdy), .parallel_out_o(pout[1]), .valid_o(vld[1]), .busy_o(bsy[1]),
    .overflow_o(ovf[1]), .level_o(lvl[1]));

  deserializer_multilane #(.DATA_WIDTH(8), .NUM_LANES(4), .LSB_FIRST(0), .FIFO_DEPTH(2)) u_n4 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .start_i(st), .serial_in_i(ser),
    .ready_i(rdy), .parallel_out_o(pout[2]), .valid_o(vld[2]), .busy_o(bsy[2]),
    .overflow_o(ovf[2]), .level_o(lvl[2]));

  // Word-level model: beats collected since the last start, FIFO as a 2-entry array.
  int         lanes_c [3] = '{1, 1, 4};
  int         lsb_c   [3] = '{0, 1, 0};
  logic [7:0] m_fifo  [3][2];
  int         m_cnt   [3];
  bit         m_inf   [3];
  int         m_nb    [3];
  logic [7:0] m_acc   [3];
  bit         m_ovf   [3];

  logic [7:0] log_w [3][64];
  int         n_log [3];

  always @(posedge clk or posedge rst) begin
    logic [7:0] beat, w;
    bit         push, pop;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_cnt[d] = 0; m_inf[d] = 0; m_nb[d] = 0; m_acc[d] = 0; m_ovf[d] = 0;
      end else begin
        beat = (lanes_c[d] == 1) ? {7'b0, ser[0]} : {4'b0, ser};
        push = 0;
        w    = 8'h00;
        if (st) begin
          m_inf[d] = 1; m_nb[d] = 0; m_acc[d] = 0;
        end
        if (en && m_inf[d]) begin
          if (lsb_c[d] != 0) m_acc[d] = m_acc[d] | (beat << (lanes_c[d] * m_nb[d]));
          else               m_acc[d] = (m_acc[d] << lanes_c[d]) | beat;
          m_nb[d]++;
        end
        if (m_inf[d] && m_nb[d] == 8 / lanes_c[d]) begin
          push = 1; w = m_acc[d]; m_inf[d] = 0; m_nb[d] = 0;
        end
        pop      = (m_cnt[d] > 0) && rdy;
        m_ovf[d] = push && (m_cnt[d] == 2) && !pop;
        if (pop) begin
          m_fifo[d][0] = m_fifo[d][1];
          m_cnt[d]--;
        end
        if (push && !m_ovf[d]) begin
          m_fifo[d][m_cnt[d]] = w;
          m_cnt[d]++;
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk("valid", d, 32'(vld[d]), 32'(m_cnt[d] > 0));
      chk("data", d, 32'(pout[d]), (m_cnt[d] > 0) ? 32'(m_fifo[d][0]) : 32'h0);
      chk("level", d, 32'(lvl[d]), 32'(m_cnt[d]));
      chk("busy", d, 32'(bsy[d]), 32'(m_inf[d]));
      chk("overflow", d, 32'(ovf[d]), 32'(m_ovf[d]));
      if (vld[d] && rdy && !rst && n_log[d] < 64) begin
        log_w[d][n_log[d]] = pout[d];
        n_log[d]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] b, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      ser = {3'b0, b[7-i]};
      en  = 1'b1;
      st  = (i == 0);
      if (rdy_last && i == 7) rdy = 1'b1;
      tick();
    end
    en = 1'b0; st = 1'b0; ser = 4'h0;
  endtask

  logic [7:0] exp0 [9] = '{8'hA5, 8'hC0, 8'h11, 8'h22, 8'h11, 8'h22, 8'h33, 8'h3C, 8'h96};
  int saved;

  initial begin
    rst = 1'b1; en = 1'b0; st = 1'b0; rdy = 1'b0; ser = 4'h0;
    repeat (2) tick();
    chk("rst_valid", 0, 32'(vld[0]), 0);
    chk("rst_level", 0, 32'(lvl[0]), 0);
    chk("rst_data", 0, 32'(pout[0]), 0);
    chk("rst_busy", 2, 32'(bsy[2]), 0);
    rst = 1'b0;
    tick();

    // Serial MSB/LSB-first words
    rdy = 1'b1;
    send8(8'hA5, 1'b0);
    chk("a5_valid", 0, 32'(vld[0]), 1);
    chk("a5_data", 0, 32'(pout[0]), 32'hA5);
    chk("a5_lsb", 1, 32'(pout[1]), 32'hA5);
    tick();
    chk("a5_onecycle", 0, 32'(vld[0]), 0);
    send8(8'hC0, 1'b0);
    chk("c0_msb", 0, 32'(pout[0]), 32'hC0);
    chk("c0_lsb", 1, 32'(pout[1]), 32'h03);
    tick();

    // Four lanes, back-to-back then with idle gaps
    ser = 4'hD; en = 1'b1; st = 1'b1; tick();
    ser = 4'h2; st = 1'b0; tick();
    en = 1'b0;
    chk("n4_valid", 2, 32'(vld[2]), 1);
    chk("n4_data", 2, 32'(pout[2]), 32'hD2);
    tick();
    ser = 4'hD; en = 1'b1; st = 1'b1; tick();
    en = 1'b0; st = 1'b0; tick(); tick();
    chk("n4_gap_wait", 2, 32'(vld[2]), 0);
    ser = 4'h2; en = 1'b1; tick();
    en = 1'b0;
    chk("n4_gap_data", 2, 32'(pout[2]), 32'hD2);
    tick();

    // Overflow with a stalled consumer
    rdy = 1'b0;
    send8(8'h11, 1'b0);
    send8(8'h22, 1'b0);
    send8(8'h33, 1'b0);
    chk("ovf_level", 0, 32'(lvl[0]), 2);
    chk("ovf_pulse", 0, 32'(ovf[0]), 1);
    tick();
    chk("ovf_clear", 0, 32'(ovf[0]), 0);
    chk("ovf_head", 0, 32'(pout[0]), 32'h11);
    rdy = 1'b1;
    repeat (3) tick();

    // Full FIFO with a pop on the completing edge
    rdy = 1'b0;
    send8(8'h11, 1'b0);
    send8(8'h22, 1'b0);
    send8(8'h33, 1'b1);
    chk("fullpop_level", 0, 32'(lvl[0]), 2);
    chk("fullpop_ovf", 0, 32'(ovf[0]), 0);
    chk("fullpop_head", 0, 32'(pout[0]), 32'h22);
    repeat (3) tick();

    // Restart at beat 5 aborts the partial word
    for (int i = 0; i < 4; i++) begin
      ser = 4'h1; en = 1'b1; st = (i == 0); tick();
    end
    send8(8'h3C, 1'b0);
    chk("abort_data", 0, 32'(pout[0]), 32'h3C);
    tick();

    // Reset mid-frame with one word queued
    rdy = 1'b0;
    send8(8'h55, 1'b0);
    ser = 4'h1; en = 1'b1; st = 1'b1; tick();
    st = 1'b0; tick(); tick();
    en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_valid", 0, 32'(vld[0]), 0);
    chk("rstmid_data", 0, 32'(pout[0]), 0);
    chk("rstmid_level", 0, 32'(lvl[0]), 0);
    chk("rstmid_busy", 0, 32'(bsy[0]), 0);
    @(posedge clk); #1 rst = 1'b0;
    rdy = 1'b1;
    saved = n_log[0];
    repeat (4) tick();
    chk("rstmid_silent", 0, 32'(n_log[0]), 32'(saved));
    send8(8'h96, 1'b0);
    chk("after_rst_data", 0, 32'(pout[0]), 32'h96);
    repeat (2) tick();

    chk("log_count", 0, 32'(n_log[0]), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("log%0d", i), 0, 32'(log_w[0][i]), 32'(exp0[i]));
    chk("log_lsb0", 1, 32'(log_w[1][0]), 32'hA5);
    chk("log_lsb1", 1, 32'(log_w[1][1]), 32'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/deserializer_multilane.md
# deserializer_multilane

Parametrised successor to the single-lane deserializer. It collects framed serial data on 1..N parallel lanes, assembles words of DATA_WIDTH bits in MSB- or LSB-first order, and delivers them through a small output FIFO with a valid/ready handshake. Overflow is reported explicitly instead of data being silently overwritten. It sits between the serial link receivers and the ECC/decode stage.

## Interface
- DATA_WIDTH, 8: assembled word width; must be a multiple of NUM_LANES.
- NUM_LANES, 1: serial lanes sampled per beat; BEATS = DATA_WIDTH/NUM_LANES.
- LSB_FIRST, 0: 0 means the first beat lands in the most significant lane group; 1 means the least significant.
- FIFO_DEPTH, 2: output FIFO entries, ≥1, power of two.
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  beat strobe; serial_in_i is sampled only when high.
- start_i  in  1  frame start; marks the first beat of a word.
- serial_in_i  in  NUM_LANES  lane data; bit k is lane k.
- ready_i  in  1  downstream accepts the current word.
- parallel_out_o  out  DATA_WIDTH  FIFO head word; '0 when valid_o is low.
- valid_o  out  1  FIFO non-empty.
- busy_o  out  1  inside a frame (in_frame).
- overflow_o  out  1  one-cycle pulse: a completed word was dropped because the FIFO was full.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- State: shift register sr[DATA_WIDTH-1:0], beat counter cnt (width $clog2(BEATS)+1), flag in_frame, FIFO (wr/rd pointers with an extra wrap bit).
- Shift on every enable_i cycle, whether or not a frame is open:
  - LSB_FIRST=0: sr <= {sr[DATA_WIDTH-NUM_LANES-1:0], serial_in_i}.
  - LSB_FIRST=1: sr <= {serial_in_i, sr[DATA_WIDTH-1:NUM_LANES]}.
  - Special case NUM_LANES=DATA_WIDTH: sr <= serial_in_i.
- Framing:
  - start_i with enable_i: in_frame=1, cnt=1. That beat is the first beat.
  - start_i without enable_i: in_frame=1, cnt=0.
  - start_i while in_frame: aborts the current partial word and restarts the count. Nothing is pushed.
  - in_frame with enable_i and no start_i: cnt += 1.
  - Word complete when in_frame, enable_i, !start_i and cnt == BEATS-1. The full word {sr shifted with the current beat} is pushed, in_frame clears and cnt clears.
  - BEATS=1: every start_i&&enable_i cycle completes a word immediately.
  - Beats with enable_i while !in_frame shift sr but never push.
- FIFO:
  - Push on word complete. Pop when valid_o && ready_i.
  - Full with a push and no pop: word dropped, overflow_o=1 for one cycle, FIFO unchanged.
  - Full with push and pop in the same cycle: both occur, level unchanged, no overflow.
  - Empty with push: word appears at the head next cycle. There is no bypass, and ready_i on that cycle is ignored because valid_o is low.
- parallel_out_o and valid_o stay stable while valid_o && !ready_i.

## Timing
- Reset (asynchronous assert; deassert synchronised by the surrounding reset logic):
  - sr, cnt, in_frame, FIFO pointers = 0.
  - valid_o=0, parallel_out_o=0, busy_o=0, overflow_o=0, level_o=0.
- Reset mid-frame: the partial word is lost. Reset with a non-empty FIFO: all entries are discarded.
- Latency: final-beat sampling edge N, then valid_o=1 from the cycle after edge N, i.e. 1 cycle after the last beat edge.
- Throughput: one word per BEATS enabled cycles. Back-to-back frames are legal: start_i on the cycle after the final beat.
- overflow_o is registered and asserts the cycle after the dropping edge.
- level_o is registered and updates on the same edge as the push/pop.
- busy_o rises the cycle after start_i and falls the cycle after the final beat.

## Test plan
- DATA_WIDTH=8, NUM_LANES=1, LSB_FIRST=0: drive start_i+enable_i with bits 1,0,1,0,0,1,0,1 on consecutive cycles, ready_i=1 → valid_o for exactly 1 cycle with parallel_out_o=8'hA5, 1 cycle after the 8th beat.
- Same stimulus with LSB_FIRST=1 → 8'hA5 bit-reversed, i.e. 8'hA5 read LSB-first gives 8'hA5? No: output must equal 8'hA5 reversed = 8'hA5 (palindromic), so use bits 1,1,0,0,0,0,0,0 instead → 8'h03 with LSB_FIRST=1, 8'hC0 with LSB_FIRST=0.
- NUM_LANES=4, DATA_WIDTH=8, LSB_FIRST=0: beats 4'hD, 4'h2 → 8'hD2 after 2 beats. Insert enable_i=0 gaps between the beats → same result, with valid_o delayed by the gap.
- FIFO_DEPTH=2, ready_i=0: send 3 frames 8'h11, 8'h22, 8'h33 → level_o=2, overflow_o pulses once after the 3rd frame. Then raise ready_i → pops 8'h11 then 8'h22; 8'h33 is never seen.
- Full FIFO, ready_i=1 on the cycle a 3rd word completes → no overflow, level_o stays 2, order 11, 22, 33 preserved.
- Re-assert start_i at beat 5 of a frame, then send 8 beats of 8'h3C → only 8'h3C is output. Assert rst_i mid-frame with 1 word queued → all outputs 0 immediately; nothing is emitted afterwards until a new frame arrives.
